// File: rtl/mem_bist_pkg.sv
// Shared types and the March C- element table for the memory BIST initiator.
package mem_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {OP_R, OP_W} op_t;

  localparam int   NUM_ELEM = 6;
  localparam int   ELEM_W   = 3;
  localparam logic SEL_D0   = 1'b0;
  localparam logic SEL_D1   = 1'b1;

  typedef struct packed {
    logic       down;
    logic [1:0] op_cnt;
    op_t        op0;
    logic       sel0;
    op_t        op1;
    logic       sel1;
  } elem_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
  function automatic elem_t elem_info(input logic [ELEM_W-1:0] e);
    elem_t info;
    case (e)
      3'd0:    info = '{down: 1'b0, op_cnt: 2'd1, op0: OP_W, sel0: SEL_D0, op1: OP_R, sel1: SEL_D0};
      3'd1:    info = '{down: 1'b0, op_cnt: 2'd2, op0: OP_R, sel0: SEL_D0, op1: OP_W, sel1: SEL_D1};
      3'd2:    info = '{down: 1'b0, op_cnt: 2'd2, op0: OP_R, sel0: SEL_D1, op1: OP_W, sel1: SEL_D0};
      3'd3:    info = '{down: 1'b1, op_cnt: 2'd2, op0: OP_R, sel0: SEL_D0, op1: OP_W, sel1: SEL_D1};
      3'd4:    info = '{down: 1'b1, op_cnt: 2'd2, op0: OP_R, sel0: SEL_D1, op1: OP_W, sel1: SEL_D0};
      default: info = '{down: 1'b0, op_cnt: 2'd1, op0: OP_R, sel0: SEL_D0, op1: OP_R, sel1: SEL_D0};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Up/down address counter for the march walk: load-to-start, step, last-address flag.
module mem_bist_addr_gen
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  // Terminal address is an explicit compare, never a wrap of the counter.
  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mem_march_bist.sv
// March C- BIST initiator for one synchronous-write, combinational-read memory port.
module mem_march_bist
  import mem_bist_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               ADDR_W = 4,
  parameter logic [WIDTH-1:0] BG     = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [7:0]        err_cnt,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_exp,
  output logic [WIDTH-1:0]  fail_got,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  state_t            state, state_n;
  logic [ELEM_W-1:0] elem, elem_n;
  logic              phase, phase_n;
  logic              ag_load, ag_load_down, ag_step, ag_last;
  logic              we_n, clear, mismatch;
  logic [WIDTH-1:0]  wdata_n, exp_data;
  elem_t             cur, nxt;
  op_t               cur_op, nxt_op;

  mem_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .down      (cur.down),
    .addr      (mem_addr),
    .last      (ag_last)
  );

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n      = state;
    elem_n       = elem;
    phase_n      = phase;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    clear        = 1'b0;
    we_n         = 1'b0;
    wdata_n      = '0;
    cur          = elem_info(elem);
    cur_op       = phase ? cur.op1 : cur.op0;
    exp_data     = (phase ? cur.sel1 : cur.sel0) ? ~BG : BG;
    mismatch     = (state == RUN) && (cur_op == OP_R) && (mem_rdata != exp_data);

    case (state)
      RUN: begin
        if ((cur.op_cnt == 2'd2) && !phase) begin
          phase_n = 1'b1;
        end else if (!ag_last) begin
          phase_n = 1'b0;
          ag_step = 1'b1;
        end else if (elem != ELEM_W'(NUM_ELEM - 1)) begin
          elem_n       = elem + ELEM_W'(1);
          phase_n      = 1'b0;
          ag_load      = 1'b1;
          ag_load_down = elem_info(elem_n).down;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        if (start) begin
          state_n = RUN;
          elem_n  = '0;
          phase_n = 1'b0;
          ag_load = 1'b1;
          clear   = 1'b1;
        end
      end
    endcase

    // Port signals are registered from the upcoming op so they line up with its cycle.
    nxt    = elem_info(elem_n);
    nxt_op = phase_n ? nxt.op1 : nxt.op0;
    if ((state_n == RUN) && (nxt_op == OP_W)) begin
      we_n    = 1'b1;
      wdata_n = (phase_n ? nxt.sel1 : nxt.sel0) ? ~BG : BG;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      elem      <= '0;
      phase     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      fail      <= 1'b0;
      err_cnt   <= '0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else begin
      state     <= state_n;
      elem      <= elem_n;
      phase     <= phase_n;
      busy      <= (state_n == RUN);
      done      <= (state_n == DONE);
      mem_we    <= we_n;
      mem_wdata <= wdata_n;
      if (clear) begin
        fail      <= 1'b0;
        err_cnt   <= '0;
        fail_elem <= '0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (!fail) begin
          fail_elem <= elem;
          fail_addr <= mem_addr;
          fail_exp  <= exp_data;
          fail_got  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_march_bist.sv
// Directed bench for mem_march_bist: 16x8 memory model with selectable read faults.
module tb_mem_march_bist;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int N      = 1 << ADDR_W;
  localparam int LIMIT  = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, fail;
  logic [7:0]        err_cnt;
  logic [2:0]        fail_elem;
  logic [ADDR_W-1:0] fail_addr;
  logic [WIDTH-1:0]  fail_exp, fail_got;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int mode = 0;  // 0 fault-free, 1 bit0 stuck-at-1 at addr 5, 2 reads return 0

  logic [WIDTH-1:0]  mem [N];
  logic              tr_we    [LIMIT];
  logic [ADDR_W-1:0] tr_addr  [LIMIT];
  logic [WIDTH-1:0]  tr_wdata [LIMIT];

  mem_march_bist dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .err_cnt   (err_cnt),
    .fail_elem (fail_elem),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_got  (fail_got),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  always_comb begin
    mem_rdata = mem[mem_addr];
    if (mode == 1 && mem_addr == 4'd5) mem_rdata[0] = 1'b1;
    if (mode == 2) mem_rdata = '0;
  end

  // Pulse start, then follow the run at negedges, recording the port activity.
  task automatic run_once(output int n);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy && n < LIMIT) begin
      tr_we[n]    = mem_we;
      tr_addr[n]  = mem_addr;
      tr_wdata[n] = mem_wdata;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, fail, mem_we} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, fail, mem_we});
    end
    checks++;
    if ({err_cnt, fail_elem, fail_addr, fail_exp, fail_got} !== '0) begin
      errors++; $display("FAIL reset_status got %h want 0", {err_cnt, fail_elem, fail_addr, fail_exp, fail_got});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_port got %h want 0", {mem_addr, mem_wdata});
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_fault_free();
    int n;
    int bad;
    mode = 0;
    run_once(n);
    checks++;
    if (n != 160) begin errors++; $display("FAIL ff_busy_cycles got %0d want 160", n); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ff_done got done=%b busy=%b want 1/0", done, busy);
    end
    checks++;
    if (fail !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL ff_status got fail=%b err=%0d want 0/0", fail, err_cnt);
    end
    bad = 0;
    for (int a = 0; a < N; a++) if (mem[a] !== 8'h00) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ff_mem_zero got %0d nonzero words want 0", bad); end
  endtask

  task automatic test_trace();
    int bad;
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (tr_we[k] !== 1'b1 || tr_addr[k] !== ADDR_W'(k) || tr_wdata[k] !== 8'h00) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL trace_m0 got %0d bad cycles want 0", bad); end
    checks++;
    if ({tr_we[16], tr_addr[16], tr_wdata[16]} !== {1'b0, 4'd0, 8'h00}) begin
      errors++; $display("FAIL trace_c16 got we=%b a=%0d d=%h want 0/0/00", tr_we[16], tr_addr[16], tr_wdata[16]);
    end
    checks++;
    if ({tr_we[17], tr_addr[17], tr_wdata[17]} !== {1'b1, 4'd0, 8'hFF}) begin
      errors++; $display("FAIL trace_c17 got we=%b a=%0d d=%h want 1/0/ff", tr_we[17], tr_addr[17], tr_wdata[17]);
    end
    checks++;
    if ({tr_we[80], tr_addr[80], tr_wdata[80]} !== {1'b0, 4'd15, 8'h00}) begin
      errors++; $display("FAIL trace_c80 got we=%b a=%0d d=%h want 0/15/00", tr_we[80], tr_addr[80], tr_wdata[80]);
    end
    checks++;
    if ({tr_we[81], tr_addr[81], tr_wdata[81]} !== {1'b1, 4'd15, 8'hFF}) begin
      errors++; $display("FAIL trace_c81 got we=%b a=%0d d=%h want 1/15/ff", tr_we[81], tr_addr[81], tr_wdata[81]);
    end
    checks++;
    if ({tr_we[82], tr_addr[82]} !== {1'b0, 4'd14}) begin
      errors++; $display("FAIL trace_c82 got we=%b a=%0d want 0/14", tr_we[82], tr_addr[82]);
    end
    checks++;
    if ({tr_we[159], tr_addr[159], tr_wdata[159]} !== {1'b0, 4'd15, 8'h00}) begin
      errors++; $display("FAIL trace_c159 got we=%b a=%0d d=%h want 0/15/00", tr_we[159], tr_addr[159], tr_wdata[159]);
    end
  endtask

  task automatic test_stuck_bit();
    int n;
    mode = 1;
    run_once(n);
    checks++;
    if (n != 160 || done !== 1'b1) begin errors++; $display("FAIL sa_len got %0d done=%b want 160/1", n, done); end
    checks++;
    if (fail !== 1'b1 || err_cnt !== 8'd3) begin
      errors++; $display("FAIL sa_count got fail=%b err=%0d want 1/3", fail, err_cnt);
    end
    checks++;
    if ({fail_elem, fail_addr, fail_exp, fail_got} !== {3'd1, 4'd5, 8'h00, 8'h01}) begin
      errors++; $display("FAIL sa_first got e=%0d a=%0d exp=%h got=%h want 1/5/00/01", fail_elem, fail_addr, fail_exp, fail_got);
    end
  endtask

  task automatic test_zero_read();
    int n;
    mode = 2;
    run_once(n);
    checks++;
    if (n != 160) begin errors++; $display("FAIL zr_len got %0d want 160", n); end
    checks++;
    if (fail !== 1'b1 || err_cnt !== 8'd32) begin
      errors++; $display("FAIL zr_count got fail=%b err=%0d want 1/32", fail, err_cnt);
    end
    checks++;
    if ({fail_elem, fail_addr, fail_exp, fail_got} !== {3'd2, 4'd0, 8'hFF, 8'h00}) begin
      errors++; $display("FAIL zr_first got e=%0d a=%0d exp=%h got=%h want 2/0/ff/00", fail_elem, fail_addr, fail_exp, fail_got);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 50; k++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, fail, err_cnt, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL mid_rst_out got %h want 0", {busy, done, fail, err_cnt, mem_we, mem_addr, mem_wdata});
    end
    @(negedge clk);
    checks++;
    if ({busy, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL mid_rst_hold got %h want 0", {busy, mem_we, mem_addr, mem_wdata});
    end
    rst = 1'b1;
    run_once(n);
    checks++;
    if (n != 160 || done !== 1'b1 || fail !== 1'b0) begin
      errors++; $display("FAIL mid_rerun got n=%0d done=%b fail=%b want 160/1/0", n, done, fail);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int dn;
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy && n < LIMIT) begin n++; @(negedge clk); end
    checks++;
    if (n != 160 || err_cnt !== 8'd32) begin
      errors++; $display("FAIL b2b_run1 got n=%0d err=%0d want 160/32", n, err_cnt);
    end
    dn = 0;
    while (!busy && dn < 10) begin
      if (done) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL b2b_done_cycles got %0d want 1", dn); end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== 8'd0 || fail !== 1'b0) begin
      errors++; $display("FAIL b2b_restart got busy=%b done=%b err=%0d fail=%b want 1/0/0/0", busy, done, err_cnt, fail);
    end
    start = 1'b0;
    n = 0;
    while (busy && n < LIMIT) begin n++; @(negedge clk); end
    checks++;
    if (n != 160 || done !== 1'b1 || err_cnt !== 8'd32) begin
      errors++; $display("FAIL b2b_run2 got n=%0d done=%b err=%0d want 160/1/32", n, done, err_cnt);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_stay_done got busy=%b done=%b want 0/1", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_trace();
    test_stuck_bit();
    test_zero_read();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
